// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: tester-side scan controller. Loads a pattern serially,
// issues one capture clock, unloads and compares the response, and keeps a
// saturating count of failing patterns.
// Optional build macro SCAN_MASK_EN adds a MASK input; masked bits are
// don't-care in the compare.
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 3,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PATTERN,
  input  logic [CHAIN_LEN-1:0] EXPECT,
`ifdef SCAN_MASK_EN
  input  logic [CHAIN_LEN-1:0] MASK,
`endif
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [CHAIN_LEN-1:0] RESPONSE,
  output logic [CNT_W-1:0]     FAIL_CNT
);

  localparam int unsigned L     = CHAIN_LEN;
  localparam int unsigned BIT_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(L - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [L-1:0]     pat_q, pat_d;
  logic [L-1:0]     exp_q;
  logic [L-1:0]     resp_q, resp_d;
  logic             se_d, si_d, busy_d, done_d;
  logic             accept, mism, finish;
`ifdef SCAN_MASK_EN
  logic [L-1:0]     mask_q;
`endif

  // State and bit counter register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
    end
  end

  // Next-state logic: L shift cycles, one capture, L unload cycles, one done
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_SHIFT;
          bit_d   = '0;
        end
      end
      S_SHIFT: begin
        if (bit_q == LAST_BIT) begin
          state_d = S_CAPTURE;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      S_CAPTURE: begin
        state_d = S_UNLOAD;
        bit_d   = '0;
      end
      S_UNLOAD: begin
        if (bit_q == LAST_BIT) begin
          state_d = S_DONE;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        bit_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so SE/SI/BUSY/DONE come out of flops
  always_comb begin
    accept = (state_q == S_IDLE) && START;
    finish = (state_q == S_UNLOAD) && (state_d == S_DONE);
    pat_d  = pat_q;
    si_d   = 1'b0;
    se_d   = (state_d == S_SHIFT) || (state_d == S_UNLOAD);
    busy_d = se_d || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
    resp_d = {resp_q[L-2:0], SO};
    // Pattern is sent MSB first out of a left-shifting copy
    if (accept) begin
      si_d  = PATTERN[L-1];
      pat_d = {PATTERN[L-2:0], 1'b0};
    end else if ((state_q == S_SHIFT) && (state_d == S_SHIFT)) begin
      si_d  = pat_q[L-1];
      pat_d = {pat_q[L-2:0], 1'b0};
    end
`ifdef SCAN_MASK_EN
    mism = |((resp_d ^ exp_q) & ~mask_q);
`else
    mism = (resp_d != exp_q);
`endif
  end

  // Chain-facing and status output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SE   <= 1'b0;
      SI   <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      SE   <= se_d;
      SI   <= si_d;
      BUSY <= busy_d;
      DONE <= done_d;
    end
  end

  // Pattern/expect latches, response shifter and compare result
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pat_q    <= '0;
      exp_q    <= '0;
      resp_q   <= '0;
      RESPONSE <= '0;
      PASS     <= 1'b0;
      FAIL_CNT <= '0;
`ifdef SCAN_MASK_EN
      mask_q   <= '0;
`endif
    end else begin
      pat_q <= pat_d;
      if (accept) begin
        exp_q  <= EXPECT;
`ifdef SCAN_MASK_EN
        mask_q <= MASK;
`endif
      end
      if (state_q == S_UNLOAD) begin
        resp_q <= resp_d;
      end
      if (finish) begin
        RESPONSE <= resp_d;
        PASS     <= !mism;
        if (mism && (FAIL_CNT != {CNT_W{1'b1}})) begin
          FAIL_CNT <= FAIL_CNT + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a 3-flop chain model whose
// functional inputs come from capd. A second instance with a 2-bit
// counter exercises saturation. Define SCAN_MASK_EN to cover masking.
module tb_scan_chain_ctrl;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start    = 1'b0;
  logic [2:0] pattern  = '0;
  logic [2:0] expect_v = '0;
  logic [2:0] capd     = '0;
`ifdef SCAN_MASK_EN
  logic [2:0] mask_v   = '0;
`endif

  logic       se_a, si_a, busy_a, done_a, pass_a, so_a;
  logic [2:0] resp_a;
  logic [7:0] fcnt_a;
  logic       se_b, si_b, busy_b, done_b, pass_b, so_b;
  logic [2:0] resp_b;
  logic [1:0] fcnt_b;
  logic [2:0] chain_a = '0;
  logic [2:0] chain_b = '0;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          lat;
  logic [19:0] se_log, si_log, busy_log;
  logic [2:0]  chain_cap;

  scan_chain_ctrl #(.CHAIN_LEN(3), .CNT_W(8)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .PATTERN(pattern), .EXPECT(expect_v),
`ifdef SCAN_MASK_EN
    .MASK(mask_v),
`endif
    .SO(so_a), .SE(se_a), .SI(si_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a),
    .RESPONSE(resp_a), .FAIL_CNT(fcnt_a)
  );

  scan_chain_ctrl #(.CHAIN_LEN(3), .CNT_W(2)) dut_sat (
    .CLK(clk), .RST_N(rst_n), .START(start), .PATTERN(pattern), .EXPECT(expect_v),
`ifdef SCAN_MASK_EN
    .MASK(mask_v),
`endif
    .SO(so_b), .SE(se_b), .SI(si_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b),
    .RESPONSE(resp_b), .FAIL_CNT(fcnt_b)
  );

  always #5 clk = ~clk;

  // Scan chain models: shift toward flop 2 when SE, else capture capd
  always @(posedge clk) begin
    if (se_a) chain_a <= {chain_a[1:0], si_a};
    else      chain_a <= capd;
    if (se_b) chain_b <= {chain_b[1:0], si_b};
    else      chain_b <= capd;
  end
  assign so_a = chain_a[2];
  assign so_b = chain_b[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one pattern; log outputs per cycle after the START edge until DONE.
  // Returns in the DONE cycle; lat = cycles after the START edge (-1 on timeout).
  task automatic run_pat(input logic [2:0] pat, input logic [2:0] cd,
                         input logic [2:0] ex, input int pulse_k);
    pattern  = pat;
    capd     = cd;
    expect_v = ex;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    lat       = -1;
    se_log    = '0;
    si_log    = '0;
    busy_log  = '0;
    chain_cap = '0;
    for (int k = 0; k < 20; k++) begin
      se_log[k]   = se_a;
      si_log[k]   = si_a;
      busy_log[k] = busy_a;
      if (k == 3) chain_cap = chain_a;
      if (done_a) begin
        lat = k;
        break;
      end
      if (k == pulse_k) start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int activity;

    // Reset values
    repeat (2) tick();
    check("rst_se",   32'(se_a),   0);
    check("rst_si",   32'(si_a),   0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_pass", 32'(pass_a), 0);
    check("rst_resp", 32'(resp_a), 0);
    check("rst_fcnt", 32'(fcnt_a), 0);
    rst_n = 1'b1;
    tick();

    // Load/capture with a matching response
    run_pat(3'b101, 3'b011, 3'b011, -1);
    check("lc_lat",     32'(lat), 7);
    check("lc_si_seq",  32'({si_log[0], si_log[1], si_log[2]}), 32'b101);
    check("lc_si_idle", 32'(si_log[7:3]), 0);
    check("lc_se_seq",  32'(se_log[7:0]), 32'b0111_0111);
    check("lc_busy",    32'(busy_log[7:0]), 32'h7F);
    check("lc_chain",   32'(chain_cap), 32'b101);
    check("lc_resp",    32'(resp_a), 32'b011);
    check("lc_pass",    32'(pass_a), 1);
    check("lc_fcnt",    32'(fcnt_a), 0);
    tick();
    check("lc_done_pulse", 32'(done_a), 0);
    check("lc_busy_idle",  32'(busy_a), 0);

    // Second load pattern
    run_pat(3'b010, 3'b110, 3'b110, -1);
    check("p2_si_seq", 32'({si_log[0], si_log[1], si_log[2]}), 32'b010);
    check("p2_chain",  32'(chain_cap), 32'b010);
    check("p2_resp",   32'(resp_a), 32'b110);
    check("p2_pass",   32'(pass_a), 1);
    tick();

    // Three mismatching patterns
    for (int n = 1; n <= 3; n++) begin
      run_pat(3'b101, 3'b011, 3'b111, -1);
      check("mm_pass",   32'(pass_a), 0);
      check("mm_resp",   32'(resp_a), 32'b011);
      check("mm_fcnt",   32'(fcnt_a), 32'(n));
      check("mm_fcnt_b", 32'(fcnt_b), 32'(n));
      tick();
    end

    // START during UNLOAD is dropped
    run_pat(3'b101, 3'b011, 3'b011, 5);
    check("ig_lat",  32'(lat), 7);
    check("ig_pass", 32'(pass_a), 1);
    check("ig_fcnt", 32'(fcnt_a), 3);
    tick();
    activity = 0;
    for (int k = 0; k < 10; k++) begin
      if (busy_a || done_a || se_a) activity++;
      tick();
    end
    check("ig_no_extra", 32'(activity), 0);

    // Saturation of the 2-bit counter
    for (int n = 4; n <= 5; n++) begin
      run_pat(3'b101, 3'b011, 3'b111, -1);
      check("sat_fcnt_a", 32'(fcnt_a), 32'(n));
      check("sat_fcnt_b", 32'(fcnt_b), 3);
      tick();
    end

    // Asynchronous reset in the middle of SHIFT
    pattern = 3'b111;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick();
    check("ab_se_pre", 32'(se_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ab_se",     32'(se_a),   0);
    check("ab_si",     32'(si_a),   0);
    check("ab_busy",   32'(busy_a), 0);
    check("ab_fcnt",   32'(fcnt_a), 0);
    check("ab_fcnt_b", 32'(fcnt_b), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    activity = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done_a || busy_a) activity++;
    end
    check("ab_no_done", 32'(activity), 0);
    run_pat(3'b101, 3'b011, 3'b011, -1);
    check("ab_lat",  32'(lat), 7);
    check("ab_resp", 32'(resp_a), 32'b011);
    check("ab_pass", 32'(pass_a), 1);
    check("ab_fcnt_after", 32'(fcnt_a), 0);
    tick();

`ifdef SCAN_MASK_EN
    // Masked bit is don't-care
    mask_v = 3'b010;
    run_pat(3'b101, 3'b010, 3'b000, -1);
    check("mk_pass", 32'(pass_a), 1);
    check("mk_fcnt", 32'(fcnt_a), 0);
    tick();
    mask_v = 3'b000;
    run_pat(3'b101, 3'b010, 3'b000, -1);
    check("mk_nomask_pass", 32'(pass_a), 0);
    check("mk_nomask_fcnt", 32'(fcnt_a), 1);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
